// File: rtl/sync_up_down_counter_mod_if.sv
// Control/status bundle for the synchronous up/down counter.
// The master side drives enable, direction and the parallel-load path.
// The slave side (the counter) returns the count, terminal count and the sticky flag.
interface sync_up_down_counter_mod_if #(
    parameter int N = 4
);
    logic         en;
    logic         sel;
    logic         load;
    logic [N-1:0] d;
    logic [N-1:0] Q;
    logic         tc;
    logic         ovf;

    modport master (
        output en, sel, load, d,
        input  Q, tc, ovf
    );

    modport slave (
        input  en, sel, load, d,
        output Q, tc, ovf
    );
endinterface

// File: rtl/sync_up_down_counter_mod.sv
// Synchronous N-bit up/down counter with a programmable modulus.
// Supports parallel load, count enable, wrap or saturate at the range ends,
// a sticky overflow flag and a combinational terminal count for cascading.
// Range-end detection compares against the range limits instead of using the
// adder carry, so MODULUS == 2**N behaves the same as any smaller modulus.
module sync_up_down_counter_mod #(
    parameter int N        = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    sync_up_down_counter_mod_if.slave   bus
);

    // Largest legal count, held at the counter width.
    localparam logic [N-1:0] MAX_V = N'(MODULUS - 1);
    // Modulus held one bit wider so that 2**N stays representable.
    localparam logic [N:0]   MOD_W = (N+1)'(MODULUS);

    logic [N-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;

    logic         at_max;
    logic         at_zero;
    logic         up_end;
    logic         dn_end;
    logic         d_legal;
    logic [N-1:0] load_val;
    logic [N-1:0] up_val;
    logic [N-1:0] dn_val;

    // Range-end detection and the candidate next values for each operation.
    always_comb begin
        at_max   = (q_q == MAX_V);
        at_zero  = (q_q == '0);
        up_end   = bus.sel & at_max;
        dn_end   = ~bus.sel & at_zero;
        d_legal  = ({1'b0, bus.d} < MOD_W);
        load_val = d_legal ? bus.d : MAX_V;
        // At the top of the range the step either wraps to 0 or holds.
        if (at_max)
            up_val = (SATURATE != 0) ? MAX_V : '0;
        else
            up_val = q_q + N'(1);
        // At the bottom of the range the step either wraps to MAX or holds.
        if (at_zero)
            dn_val = (SATURATE != 0) ? '0 : MAX_V;
        else
            dn_val = q_q - N'(1);
    end

    // Next state: load beats count; reset is applied in the register itself.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (bus.load) begin
            q_d   = load_val;
            ovf_d = 1'b0;
        end else if (bus.en) begin
            q_d = bus.sel ? up_val : dn_val;
            // Any wrap or saturation event marks the flag; it stays until reset/load.
            if (up_end || dn_end)
                ovf_d = 1'b1;
        end
    end

    // State register with synchronous, highest-priority reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs: tc is deliberately not gated by load or reset so a cascade
    // sees the carry purely from enable, direction and the current count.
    always_comb begin
        bus.Q   = q_q;
        bus.ovf = ovf_q;
        bus.tc  = bus.en & (up_end | dn_end);
    end

endmodule

// File: tb/tb_sync_up_down_counter_mod.sv
// Bench for the synchronous up/down counter: vector tables for a wrap
// (MODULUS=10), a saturating and a full-range (MODULUS=16) instance, plus a
// two-digit decade cascade run through 100 counts.
module tb_sync_up_down_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_s, rst_f, rst_c;

    sync_up_down_counter_mod_if #(.N(4)) m_if ();
    sync_up_down_counter_mod_if #(.N(4)) s_if ();
    sync_up_down_counter_mod_if #(.N(4)) f_if ();
    sync_up_down_counter_mod_if #(.N(4)) u_if ();
    sync_up_down_counter_mod_if #(.N(4)) t_if ();

    sync_up_down_counter_mod #(.N(4), .MODULUS(10), .SATURATE(0)) dut_m (
        .clk(clk), .reset(rst_m), .bus(m_if.slave));
    sync_up_down_counter_mod #(.N(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .reset(rst_s), .bus(s_if.slave));
    sync_up_down_counter_mod #(.N(4), .MODULUS(16), .SATURATE(0)) dut_f (
        .clk(clk), .reset(rst_f), .bus(f_if.slave));
    sync_up_down_counter_mod #(.N(4), .MODULUS(10), .SATURATE(0)) dut_u (
        .clk(clk), .reset(rst_c), .bus(u_if.slave));
    sync_up_down_counter_mod #(.N(4), .MODULUS(10), .SATURATE(0)) dut_t (
        .clk(clk), .reset(rst_c), .bus(t_if.slave));

    // Tens digit counts up whenever the units digit carries.
    assign t_if.en   = u_if.tc;
    assign t_if.sel  = 1'b1;
    assign t_if.load = 1'b0;
    assign t_if.d    = 4'd0;

    typedef struct {
        int unit;
        bit rst, ld, en, sel;
        int d;
        bit tc;     // expected before the edge
        int q;      // expected after the edge
        bit ovf;    // expected after the edge
    } vec_t;

    typedef struct {
        int idx;
        int unit;
        int q;
        bit ovf;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input int u, input bit rst, input bit ld, input bit en, input bit sel,
                       input int d, input bit tc, input int q, input bit ovf);
        vec_t v;
        v.unit = u; v.rst = rst; v.ld = ld; v.en = en; v.sel = sel;
        v.d = d; v.tc = tc; v.q = q; v.ovf = ovf;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_m = 1'b0; rst_s = 1'b0; rst_f = 1'b0;
        m_if.en = 1'b0; m_if.sel = 1'b0; m_if.load = 1'b0; m_if.d = 4'd0;
        s_if.en = 1'b0; s_if.sel = 1'b0; s_if.load = 1'b0; s_if.d = 4'd0;
        f_if.en = 1'b0; f_if.sel = 1'b0; f_if.load = 1'b0; f_if.d = 4'd0;
        case (v.unit)
            0: begin rst_m = v.rst; m_if.en = v.en; m_if.sel = v.sel; m_if.load = v.ld; m_if.d = 4'(v.d); end
            1: begin rst_s = v.rst; s_if.en = v.en; s_if.sel = v.sel; s_if.load = v.ld; s_if.d = 4'(v.d); end
            default: begin rst_f = v.rst; f_if.en = v.en; f_if.sel = v.sel; f_if.load = v.ld; f_if.d = 4'(v.d); end
        endcase
    endtask

    function automatic int get_q(input int u);
        case (u)
            0: return int'(m_if.Q);
            1: return int'(s_if.Q);
            default: return int'(f_if.Q);
        endcase
    endfunction

    function automatic int get_tc(input int u);
        case (u)
            0: return int'(m_if.tc);
            1: return int'(s_if.tc);
            default: return int'(f_if.tc);
        endcase
    endfunction

    function automatic int get_ovf(input int u);
        case (u)
            0: return int'(m_if.ovf);
            1: return int'(s_if.ovf);
            default: return int'(f_if.ovf);
        endcase
    endfunction

    initial begin
        vec_t v;
        exp_t e;
        int   cnt;

        // ---- wrap instance, MODULUS=10 ----
        add(0, 1,0,0,0, 0,  0, 0,0);                // reset
        for (int k = 0; k < 12; k++)                 // up 12 clocks: 1..9,0,1,2
            add(0, 0,0,1,1, 0, (k % 10) == 9, (k + 1) % 10, k >= 9);
        add(0, 0,1,1,1, 3,  0, 3,0);                // load 3, en/sel ignored
        add(0, 0,0,1,0, 0,  0, 2,0);
        add(0, 0,0,1,0, 0,  0, 1,0);
        add(0, 0,0,1,0, 0,  0, 0,0);
        add(0, 0,0,1,0, 0,  1, 9,1);                // 0 -> 9 wrap
        add(0, 0,0,1,0, 0,  0, 8,1);
        add(0, 0,1,0,0, 13, 0, 9,0);                // out-of-range load clamps
        add(0, 0,1,1,1, 4,  1, 4,0);                // tc not gated by load
        add(0, 0,1,0,0, 0,  0, 0,0);
        add(0, 0,0,1,0, 0,  1, 9,1);
        add(0, 1,1,1,0, 5,  0, 0,0);                // reset beats load
        add(0, 0,1,0,0, 10, 0, 9,0);                // d == MODULUS clamps
        add(0, 0,0,1,1, 0,  1, 0,1);
        add(0, 0,0,0,1, 0,  0, 0,1);                // en=0: hold, ovf sticky
        add(0, 0,0,0,0, 0,  0, 0,1);
        add(0, 0,0,0,1, 0,  0, 0,1);
        add(0, 0,0,0,0, 0,  0, 0,1);
        add(0, 0,1,0,0, 5,  0, 5,0);
        add(0, 0,0,1,1, 0,  0, 6,0);
        add(0, 1,0,1,1, 0,  0, 0,0);                // reset mid-count at 6
        add(0, 0,0,1,1, 0,  0, 1,0);
        add(0, 0,0,1,0, 0,  0, 0,0);                // direction change, no dead cycle
        // ---- saturating instance ----
        add(1, 1,0,0,0, 0,  0, 0,0);
        add(1, 0,1,0,0, 7,  0, 7,0);
        add(1, 0,0,1,1, 0,  0, 8,0);
        add(1, 0,0,1,1, 0,  0, 9,0);
        add(1, 0,0,1,1, 0,  1, 9,1);
        add(1, 0,0,1,1, 0,  1, 9,1);
        add(1, 0,0,1,1, 0,  1, 9,1);
        add(1, 0,0,1,0, 0,  0, 8,1);
        add(1, 0,1,0,0, 1,  0, 1,0);
        add(1, 0,0,1,0, 0,  0, 0,0);
        add(1, 0,0,1,0, 0,  1, 0,1);
        add(1, 0,0,1,0, 0,  1, 0,1);
        // ---- full-range instance, MODULUS=16 ----
        add(2, 1,0,0,0, 0,  0, 0,0);
        add(2, 0,1,0,0, 15, 0, 15,0);
        add(2, 0,0,1,1, 0,  1, 0,1);
        add(2, 0,0,1,0, 0,  1, 15,1);
        add(2, 0,1,0,0, 14, 0, 14,0);
        add(2, 0,0,1,1, 0,  0, 15,0);

        rst_c = 1'b0;
        u_if.en = 1'b0; u_if.sel = 1'b1; u_if.load = 1'b0; u_if.d = 4'd0;
        v = vt[0];
        v.unit = 0; v.rst = 0; v.ld = 0; v.en = 0;
        drive(v);
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            drive(v);
            #2;
            check($sformatf("v%0d.tc", i), get_tc(v.unit), int'(v.tc));
            e.idx = i; e.unit = v.unit; e.q = v.q; e.ovf = v.ovf;
            sb.push_back(e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL v%0d.sb: got empty queue, expected one entry", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d.q", e.idx),   get_q(e.unit),   e.q);
                check($sformatf("v%0d.ovf", e.idx), get_ovf(e.unit), int'(e.ovf));
            end
        end

        // ---- decade cascade: 00..99 then 00 ----
        rst_c = 1'b1;
        @(posedge clk); #1;
        rst_c = 1'b0;
        check("casc.rst", int'(t_if.Q) * 10 + int'(u_if.Q), 0);
        cnt = 0;
        for (int i = 0; i < 99; i++) begin
            u_if.en = 1'b1;
            #2;
            check($sformatf("casc%0d.utc", i), int'(u_if.tc), int'((cnt % 10) == 9));
            check($sformatf("casc%0d.ttc", i), int'(t_if.tc), 0);
            @(posedge clk); #1;
            cnt = cnt + 1;
            check($sformatf("casc%0d.q", i), int'(t_if.Q) * 10 + int'(u_if.Q), cnt);
        end
        // At 99 with units disabled the tens carry must stay low.
        u_if.en = 1'b0;
        #2;
        check("casc99.ttc_off", int'(t_if.tc), 0);
        @(posedge clk); #1;
        check("casc99.hold", int'(t_if.Q) * 10 + int'(u_if.Q), 99);
        u_if.en = 1'b1;
        #2;
        check("casc99.ttc_on", int'(t_if.tc), 1);
        @(posedge clk); #1;
        check("casc.wrap", int'(t_if.Q) * 10 + int'(u_if.Q), 0);
        check("casc.tovf", int'(t_if.ovf), 1);
        u_if.en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
